// File: rtl/stream_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_loader_pkg
// Description : Shared constants, FSM state type and helper for the stream
//               loader. The loader streams weight and picture bytes from a
//               source memory into an accelerator and collects its results.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_loader_pkg;

   localparam int W_BYTES   = 54;    // weight bytes per run
   localparam int PIC_BYTES = 64;    // data bytes per picture
   localparam int ADDR_W    = 13;    // source address width
   localparam int MAX_PICS  = 100;   // largest picture count honoured
   localparam int CNT_W     = 7;     // width of picture count / result index

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_W_LOAD = 3'd1,
      ST_D_LOAD = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   // Clamp a requested picture count to the supported maximum.
   function automatic logic [CNT_W-1:0] sat_pics(input logic [CNT_W-1:0] n);
      return (n > CNT_W'(MAX_PICS)) ? CNT_W'(MAX_PICS) : n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/stream_loader_result_capture.sv
`default_nettype none
// ============================================================================
// Module      : result_capture
// Description : Detects rising edges of the accelerator result flag, captures
//               the result byte with its picture index and counts results.
//               Edges outside a run, or beyond the expected count, are dropped.
// Ports       : clk, rst_n        clock, synchronous active-low reset
//               i_clr             clear the result counter (run accepted)
//               i_active          a run is in progress (FSM not idle)
//               i_num_pics        expected results for this run
//               i_acc_dout        accelerator result byte
//               i_acc_out_flag    accelerator result flag
//               o_res_valid       one-cycle strobe with captured result
//               o_res_data        captured result byte
//               o_res_idx         picture index of o_res_data
//               o_res_cnt         results counted so far in this run
// Revision    : 1.0 - initial release
// ============================================================================
module result_capture
   import stream_loader_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_active,
   input  logic [CNT_W-1:0] i_num_pics,
   input  logic [7:0]       i_acc_dout,
   input  logic             i_acc_out_flag,
   output logic             o_res_valid,
   output logic [7:0]       o_res_data,
   output logic [CNT_W-1:0] o_res_idx,
   output logic [CNT_W-1:0] o_res_cnt
);

   logic             r_flag_d;
   logic [CNT_W-1:0] r_cnt;
   logic             w_take;

   // A flag held high produces a single edge; results past the expected
   // count are ignored so a late or spurious flag cannot overrun the index.
   assign w_take    = i_acc_out_flag & ~r_flag_d & i_active & (r_cnt < i_num_pics);
   assign o_res_cnt = r_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_flag_d    <= 1'b0;
         r_cnt       <= '0;
         o_res_valid <= 1'b0;
         o_res_data  <= '0;
         o_res_idx   <= '0;
      end else begin
         r_flag_d    <= i_acc_out_flag;
         o_res_valid <= w_take;
         if (i_clr) begin
            r_cnt <= '0;
         end else if (w_take) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_take) begin
            o_res_data <= i_acc_dout;
            o_res_idx  <= r_cnt;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : stream_loader
// Description : Reads W_BYTES weight bytes followed by num_pics pictures of
//               PIC_BYTES each from a source memory and streams them, gap
//               free, into an accelerator. Results flagged by the accelerator
//               are captured and reported with their picture index.
// Ports       : clk, rst_n              clock, synchronous active-low reset
//               start, num_pics         run request and pictures per run
//               src_en/src_addr/src_rdata  source memory read port (1-cycle)
//               acc_mode/acc_din/acc_ram_en  byte stream to accelerator
//               acc_dout/acc_out_flag   accelerator result interface
//               res_valid/res_data/res_idx  captured results
//               busy, done              run status
// Revision    : 1.0 - initial release
// ============================================================================
module stream_loader
   import stream_loader_pkg::*;
#(
   parameter int W_BYTES   = stream_loader_pkg::W_BYTES,
   parameter int PIC_BYTES = stream_loader_pkg::PIC_BYTES,
   parameter int ADDR_W    = stream_loader_pkg::ADDR_W
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [6:0]        num_pics,
   output logic              src_en,
   output logic [ADDR_W-1:0] src_addr,
   input  logic [7:0]        src_rdata,
   output logic              acc_mode,
   output logic [7:0]        acc_din,
   output logic              acc_ram_en,
   input  logic [7:0]        acc_dout,
   input  logic              acc_out_flag,
   output logic              res_valid,
   output logic [7:0]        res_data,
   output logic [6:0]        res_idx,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] c_w_last    = ADDR_W'(W_BYTES - 1);
   localparam logic [ADDR_W-1:0] c_pic_bytes = ADDR_W'(PIC_BYTES);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_last_addr;
   logic [6:0]        r_npics;
   logic [6:0]        w_npics_sat;
   logic [6:0]        w_res_cnt;
   logic              w_accept;
   logic              w_loading;
   logic              w_active;
   logic              w_pipe_empty;

   // Byte pipe: stage 1 tracks the read issued last cycle, stage 2 holds the
   // returned byte, the output stage presents it to the accelerator.
   logic              r_en_s1;
   logic              r_mode_s1;
   logic              r_en_s2;
   logic              r_mode_s2;
   logic [7:0]        r_din_s2;

   assign w_npics_sat  = sat_pics(num_pics);
   assign w_pipe_empty = ~(r_en_s1 | r_en_s2 | acc_ram_en);
   assign src_addr     = r_addr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_loading   = 1'b0;
      w_active    = 1'b1;
      busy        = 1'b1;
      done        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_active = 1'b0;
            busy     = 1'b0;
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_W_LOAD;
            end
         end
         ST_W_LOAD: begin
            w_loading = 1'b1;
            if (r_addr == c_w_last) begin
               w_state_nxt = (r_npics == 7'd0) ? ST_DRAIN : ST_D_LOAD;
            end
         end
         ST_D_LOAD: begin
            w_loading = 1'b1;
            if (r_addr == r_last_addr) begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if ((w_res_cnt == r_npics) && w_pipe_empty) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            done        = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      src_en = w_loading;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_addr      <= '0;
         r_last_addr <= '0;
         r_npics     <= '0;
         r_en_s1     <= 1'b0;
         r_mode_s1   <= 1'b0;
         r_en_s2     <= 1'b0;
         r_mode_s2   <= 1'b0;
         r_din_s2    <= '0;
         acc_ram_en  <= 1'b0;
         acc_mode    <= 1'b0;
         acc_din     <= '0;
      end else begin
         if (w_accept) begin
            r_npics     <= w_npics_sat;
            // Last picture byte sits at W_BYTES + n*PIC_BYTES - 1.
            r_last_addr <= c_w_last + c_pic_bytes * ADDR_W'(w_npics_sat);
         end
         // Address runs continuously across the weight/data boundary and
         // parks at zero whenever no read is being issued.
         r_addr     <= w_loading ? (r_addr + ADDR_W'(1)) : '0;
         r_en_s1    <= w_loading;
         r_mode_s1  <= (r_state == ST_W_LOAD);
         r_en_s2    <= r_en_s1;
         r_mode_s2  <= r_mode_s1;
         r_din_s2   <= src_rdata;
         acc_ram_en <= r_en_s2;
         acc_mode   <= r_mode_s2;
         acc_din    <= r_din_s2;
      end
   end

   result_capture u_result_capture (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_clr          (w_accept),
      .i_active       (w_active),
      .i_num_pics     (r_npics),
      .i_acc_dout     (acc_dout),
      .i_acc_out_flag (acc_out_flag),
      .o_res_valid    (res_valid),
      .o_res_data     (res_data),
      .o_res_idx      (res_idx),
      .o_res_cnt      (w_res_cnt)
   );

endmodule
`default_nettype wire
